// File: rtl/vec_pipe_pkg.sv
// Shared types and helpers for the vector pipeline front end.
//   INSTR_W / ADDR_W : instruction and address widths
//   fetch_entry_t    : one fetched word together with its byte address
//   word_align       : clears the byte-offset bits of an address
package vec_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular buffer of fetch_entry_t between instruction memory and Decode.
//   clk, RST   : clock, asynchronous active-high reset
//   push       : write push_entry at the tail
//   pop        : retire the head entry
//   clear      : drop every entry; wins over push and pop
//   head       : current head entry (last shown head while empty)
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import vec_pipe_pkg::*;
#(
  parameter int           DEPTH      = 2,
  parameter fetch_entry_t RESET_HEAD = '0,
  localparam int          PTR_W      = $clog2(DEPTH),
  localparam int          CNT_W      = PTR_W + 1
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               clear,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t             mem_r [DEPTH];
  fetch_entry_t             last_head_r;
  fetch_entry_t             head_s;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [CNT_W-1:0]         count_r;

  // Pointer and occupancy bookkeeping; clear resets everything to empty.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_r[wr_ptr_r] <= push_entry;
  end

  // While empty, keep presenting whatever head was shown last.
  always_comb begin
    if (count_r != '0) head_s = mem_r[rd_ptr_r];
    else               head_s = last_head_r;
  end

  // Remember the presented head for the empty case.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) last_head_r <= RESET_HEAD;
    else     last_head_r <= head_s;
  end

  assign head  = head_s;
  assign count = count_r;

endmodule

// File: rtl/vec_fetch_stage.sv
// Instruction-fetch stage feeding Decode.
// Issues one-word reads to a 1-cycle-latency instruction memory, queues the
// returned words and presents the queue head to Decode. Redirects flush the
// queue and any arriving wrong-path word, and restart fetch at the target.
//   clk, RST                 : clock, asynchronous active-high reset
//   imem_req/imem_addr       : read request and word-aligned byte address
//   imem_rdata               : read data, one cycle after the request
//   stall_d                  : Decode cannot take the head this cycle
//   redirect/redirect_pc     : new fetch target (bits [1:0] ignored)
//   InstrD/PCD/PCPlus4D      : head instruction, its address, address + 4
//   valid_d                  : head is a real instruction
//   stall_cycles/redirects   : performance counters, only with FETCH_PERF_EN
// Optional feature macro: FETCH_PERF_EN.
module vec_fetch_stage
  import vec_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirects
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;

  logic [31:0]      pc_r;
  logic [31:0]      req_addr_r;
  logic             inflight_r;
  logic [CNT_W-1:0] count_s;
  logic [CRD_W-1:0] credit_s;
  logic [31:0]      addr_s;
  logic             valid_s;
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_entry_s;

  // Issue/credit logic: a request is only sent if its word is guaranteed a
  // queue slot, counting what Decode retires this cycle. Redirects always issue.
  always_comb begin
    valid_s      = (count_s != '0) && !redirect;
    pop_s        = valid_s && !stall_d;
    credit_s     = CRD_W'(count_s) + CRD_W'(inflight_r) - CRD_W'(pop_s);
    issue_s      = redirect || (credit_s < CRD_W'(DEPTH));
    addr_s       = redirect ? word_align(redirect_pc) : pc_r;
    push_s       = inflight_r && !redirect;
    push_entry_s = '{instr: imem_rdata, pc: req_addr_r};
  end

  // Sequential PC, in-flight flag and address of the outstanding request.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r       <= addr_s + 32'd4;
        req_addr_r <= addr_s;
      end
    end
  end

  fetch_queue #(
    .DEPTH      (DEPTH),
    .RESET_HEAD (fetch_entry_t'{instr: 32'h0000_0000, pc: RESET_PC})
  ) u_queue (
    .clk        (clk),
    .RST        (RST),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .clear      (redirect),
    .head       (head_s),
    .count      (count_s)
  );

  assign imem_req  = issue_s && !RST;
  assign imem_addr = addr_s;
  assign InstrD    = head_s.instr;
  assign PCD       = head_s.pc;
  assign PCPlus4D  = head_s.pc + 32'd4;
  assign valid_d   = valid_s;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] redirects_r;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stall_cycles_r <= 32'd0;
      redirects_r    <= 32'd0;
    end else begin
      if (valid_s && stall_d) stall_cycles_r <= stall_cycles_r + 32'd1;
      if (redirect)           redirects_r    <= redirects_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign redirects    = redirects_r;
`endif

endmodule
